sdram_access_arbiter: RTL and testbench

//  Sequences and shares the SDRAM single-word interface (CMD 0 idle/1 read/2 write, STATUS=busy) between
//  two requesters: the logger write stream (auto-incrementing write pointer) and the downlink read port
//  (random address). Sits between the logging/telemetry logic and sdram_interface; owns all CMD/address

---
 rtl/sdram_pkg.sv | 42 ++++
 rtl/sdram_rr_arbiter.sv | 38 +++
 rtl/sdram_access_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sdram_access_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM arbiter definitions: command codes, FSM states, address field layout.
package sdram_pkg;

    localparam int unsigned BANK_W   = 2;
    localparam int unsigned ROW_W    = 13;
    localparam int unsigned COL_W    = 9;
    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned COL_LSB  = 0;
    localparam int unsigned ROW_LSB  = COL_LSB + COL_W;
    localparam int unsigned BANK_LSB = ROW_LSB + ROW_W;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } cmd_e;

    typedef enum logic [2:0] {
        ST_INIT_HI,
        ST_INIT_LO,
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } sdram_addr_t;

    function automatic sdram_addr_t decode_addr(input logic [ADDR_W-1:0] addr);
        sdram_addr_t d;
        d.bank = addr[BANK_LSB +: BANK_W];
        d.row  = addr[ROW_LSB +: ROW_W];
        d.col  = addr[COL_LSB +: COL_W];
        return d;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Two-way round-robin grant between the write stream and the read port.
module sdram_rr_arbiter (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_grant_en,
    input  logic i_wr_req,
    input  logic i_rd_req,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    logic r_last_wr;

    always_comb begin
        o_gnt_wr = 1'b0;
        o_gnt_rd = 1'b0;
        if (i_grant_en) begin
            if (i_wr_req && i_rd_req) begin
                o_gnt_wr = ~r_last_wr;
                o_gnt_rd = r_last_wr;
            end else begin
                o_gnt_wr = i_wr_req;
                o_gnt_rd = i_rd_req;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_wr <= 1'b0;
        end else if (o_gnt_wr) begin
            r_last_wr <= 1'b1;
        end else if (o_gnt_rd) begin
            r_last_wr <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_access_arbiter.sv
// Shares the SDRAM single-word port between the logger write stream and the downlink read port.
// Define SDRAM_WRAP_EN to make the write pointer wrap (ring buffer) instead of stopping when full.
module sdram_access_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned       ISSUE_TIMEOUT = 16,
    parameter int unsigned       BUSY_TIMEOUT  = 64,
    parameter logic [ADDR_W-1:0] ADDR_MAX      = 24'hFFFFFF
) (
    input  logic              CLK_48MHZ,
    input  logic              RESET,
    input  logic              WR_REQ,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_ACK,
    output logic              WR_DROP,
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic [ADDR_W-1:0] WR_PTR,
    output logic              MEM_FULL,
    output logic              READY,
    output logic              FAULT,
    output logic [1:0]        CMD_OUT,
    output logic [BANK_W-1:0] A_OUT_BANK,
    output logic [ROW_W-1:0]  A_OUT_ROW,
    output logic [COL_W-1:0]  A_OUT_COL,
    output logic [DATA_W-1:0] D_OUT,
    input  logic              SDRAM_STATUS,
    input  logic [DATA_W-1:0] SDRAM_DATA_READ
);

    localparam int unsigned T_MAX = (ISSUE_TIMEOUT > BUSY_TIMEOUT) ? ISSUE_TIMEOUT : BUSY_TIMEOUT;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    state_e              r_state, w_next;
    cmd_e                w_cmd;
    logic                r_op_wr, r_ready, r_fault, r_full;
    logic                r_wr_ack, r_wr_drop, r_rd_valid;
    logic [ADDR_W-1:0]   r_addr, r_wr_ptr;
    logic [DATA_W-1:0]   r_dout, r_rd_data;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_grant_en, w_wr_pend, w_rd_pend, w_gnt_wr, w_gnt_rd;
    logic                w_start, w_issue_to, w_busy_to, w_wr_last;
    sdram_addr_t         w_dec;

    // Mask a requester during its own ack cycle so a late-dropping REQ is not re-granted.
    assign w_grant_en = (r_state == ST_IDLE);
    assign w_wr_pend  = WR_REQ & ~r_wr_ack;
    assign w_rd_pend  = RD_REQ & ~r_rd_valid;

    sdram_rr_arbiter u_rr (
        .i_clk      (CLK_48MHZ),
        .i_rst_n    (RESET),
        .i_grant_en (w_grant_en),
        .i_wr_req   (w_wr_pend),
        .i_rd_req   (w_rd_pend),
        .o_gnt_wr   (w_gnt_wr),
        .o_gnt_rd   (w_gnt_rd)
    );

    assign w_start    = w_gnt_rd | (w_gnt_wr & ~r_full);
    assign w_issue_to = (r_cnt >= CNT_W'(ISSUE_TIMEOUT)) & ~SDRAM_STATUS;
    assign w_busy_to  = (r_cnt >= CNT_W'(BUSY_TIMEOUT)) & SDRAM_STATUS;
    assign w_wr_last  = (r_wr_ptr == ADDR_MAX);
    assign w_dec      = decode_addr(r_addr);

    always_comb begin
        w_next = r_state;
        w_cmd  = CMD_IDLE;
        case (r_state)
            ST_INIT_HI: if (SDRAM_STATUS) w_next = ST_INIT_LO;
            ST_INIT_LO: if (!SDRAM_STATUS) w_next = ST_IDLE;
            ST_IDLE:    if (w_start) w_next = ST_ISSUE;
            ST_ISSUE: begin
                w_cmd = r_op_wr ? CMD_WRITE : CMD_READ;
                if (SDRAM_STATUS)    w_next = ST_BUSY;
                else if (w_issue_to) w_next = ST_IDLE;
            end
            ST_BUSY: begin
                if (!SDRAM_STATUS)  w_next = ST_DONE;
                else if (w_busy_to) w_next = ST_IDLE;
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_INIT_HI;
        endcase
    end

    always_ff @(posedge CLK_48MHZ) begin
        if (!RESET) begin
            r_state    <= ST_INIT_HI;
            r_op_wr    <= 1'b0;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
            r_full     <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_wr_drop  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_addr     <= '0;
            r_wr_ptr   <= '0;
            r_dout     <= '0;
            r_rd_data  <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_next;
            r_wr_ack   <= 1'b0;
            r_wr_drop  <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_INIT_LO: if (!SDRAM_STATUS) r_ready <= 1'b1;
                ST_IDLE: begin
                    r_cnt <= CNT_W'(1);
                    if (w_gnt_wr && r_full) begin
                        r_wr_ack  <= 1'b1;
                        r_wr_drop <= 1'b1;
                    end else if (w_gnt_wr) begin
                        r_op_wr <= 1'b1;
                        r_addr  <= r_wr_ptr;
                        r_dout  <= WR_DATA;
                    end else if (w_gnt_rd) begin
                        r_op_wr <= 1'b0;
                        r_addr  <= RD_ADDR;
                        r_dout  <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= SDRAM_STATUS ? CNT_W'(1) : r_cnt + CNT_W'(1);
                    if (w_issue_to) r_fault <= 1'b1;
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_busy_to) r_fault <= 1'b1;
                    if (!SDRAM_STATUS) begin
                        if (r_op_wr) begin
                            r_wr_ack <= 1'b1;
`ifdef SDRAM_WRAP_EN
                            r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + ADDR_W'(1);
`else
                            if (w_wr_last) r_full   <= 1'b1;
                            else           r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
`endif
                        end else begin
                            r_rd_data  <= SDRAM_DATA_READ;
                            r_rd_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign CMD_OUT    = w_cmd;
    assign A_OUT_BANK = w_dec.bank;
    assign A_OUT_ROW  = w_dec.row;
    assign A_OUT_COL  = w_dec.col;
    assign D_OUT      = r_dout;
    assign WR_ACK     = r_wr_ack;
    assign WR_DROP    = r_wr_drop;
    assign RD_VALID   = r_rd_valid;
    assign RD_DATA    = r_rd_data;
    assign WR_PTR     = r_wr_ptr;
    assign MEM_FULL   = r_full;
    assign READY      = r_ready;
    assign FAULT      = r_fault;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Scoreboard bench for sdram_access_arbiter with a behavioural SDRAM and a transaction-level reference.
module tb_sdram_access_arbiter;
    import sdram_pkg::*;

    localparam logic [23:0] AMAX = 24'd63;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [15:0] wr_data = '0;
    logic [23:0] rd_addr = '0;
    logic        sd_status = 1'b0;
    logic [15:0] sd_rdata = '0;
    logic        wr_ack, wr_drop, rd_valid, mem_full, ready, fault;
    logic [15:0] rd_data, d_out;
    logic [23:0] wr_ptr;
    logic [1:0]  cmd_out, a_bank;
    logic [12:0] a_row;
    logic [8:0]  a_col;

    sdram_access_arbiter #(.ISSUE_TIMEOUT(16), .BUSY_TIMEOUT(64), .ADDR_MAX(AMAX)) dut (
        .CLK_48MHZ(clk), .RESET(rst_n),
        .WR_REQ(wr_req), .WR_DATA(wr_data), .WR_ACK(wr_ack), .WR_DROP(wr_drop),
        .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_VALID(rd_valid),
        .WR_PTR(wr_ptr), .MEM_FULL(mem_full), .READY(ready), .FAULT(fault),
        .CMD_OUT(cmd_out), .A_OUT_BANK(a_bank), .A_OUT_ROW(a_row), .A_OUT_COL(a_col),
        .D_OUT(d_out), .SDRAM_STATUS(sd_status), .SDRAM_DATA_READ(sd_rdata)
    );

    always #10 clk = ~clk;

    typedef struct { logic [1:0] cmd; logic [23:0] addr; logic [15:0] data; } cmd_t;
    typedef struct { logic drop; logic [23:0] ptr; logic full; } wr_exp_t;

    cmd_t        exp_cmd[$];
    wr_exp_t     exp_wr[$];
    logic [15:0] exp_rd[$];
    logic        exp_order[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] env_mem[logic [23:0]];
    logic [15:0] ref_mem[logic [23:0]];
    logic [23:0] m_ptr = '0;
    logic        m_full = 1'b0;
    logic        m_last_wr = 1'b0;
    int          env_mode = 1;
    int          env_issue_lat = 0;
    int          env_busy_len = 12;
    logic [1:0]  last_bank;
    logic [12:0] last_row;
    logic [8:0]  last_col;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur at %0t", name, $time);
    endtask

    function automatic logic [15:0] bg(input logic [23:0] a);
        return a[15:0] ^ a[23:8] ^ 16'h5A3C;
    endfunction

    // Reference: what each granted access must produce, in grant order.
    task automatic model_write(input logic [15:0] wd);
        wr_exp_t e;
        exp_order.push_back(1'b1);
        m_last_wr = 1'b1;
        if (m_full) begin
            e = '{drop: 1'b1, ptr: m_ptr, full: 1'b1};
        end else begin
            exp_cmd.push_back('{cmd: 2'd2, addr: m_ptr, data: wd});
            ref_mem[m_ptr] = wd;
`ifdef SDRAM_WRAP_EN
            m_ptr = (m_ptr == AMAX) ? 24'd0 : m_ptr + 24'd1;
`else
            if (m_ptr == AMAX) m_full = 1'b1;
            else               m_ptr  = m_ptr + 24'd1;
`endif
            e = '{drop: 1'b0, ptr: m_ptr, full: m_full};
        end
        exp_wr.push_back(e);
    endtask

    task automatic model_read(input logic [23:0] ra);
        exp_order.push_back(1'b0);
        m_last_wr = 1'b0;
        exp_cmd.push_back('{cmd: 2'd1, addr: ra, data: 16'h0});
        exp_rd.push_back(ref_mem.exists(ra) ? ref_mem[ra] : bg(ra));
    endtask

    task automatic do_phase(input bit w, input logic [15:0] wd, input bit r, input logic [23:0] ra);
        if (w && r) begin
            if (!m_last_wr) begin model_write(wd); model_read(ra); end
            else            begin model_read(ra);  model_write(wd); end
        end else if (w) begin
            model_write(wd);
        end else if (r) begin
            model_read(ra);
        end
        fork
            if (w) begin
                bit got = 1'b0;
                wr_data = wd;
                wr_req  = 1'b1;
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk); #1;
                    if (wr_ack) begin got = 1'b1; break; end
                end
                wr_req = 1'b0;
                if (!got) fail_now("wr_ack_timeout");
            end
            if (r) begin
                bit got = 1'b0;
                rd_addr = ra;
                rd_req  = 1'b1;
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk); #1;
                    if (rd_valid) begin got = 1'b1; break; end
                end
                rd_req = 1'b0;
                if (!got) fail_now("rd_valid_timeout");
            end
        join
        @(posedge clk); #1;
    endtask

    // Behavioural SDRAM: raise STATUS after a command, hold busy, then complete.
    initial begin
        cmd_t        e;
        logic [1:0]  c;
        logic [23:0] a;
        logic [15:0] d;
        forever begin
            @(posedge clk); #1;
            if (env_mode == 0 && cmd_out != 2'd0) begin
                c = cmd_out;
                a = {a_bank, a_row, a_col};
                d = d_out;
                last_bank = a_bank; last_row = a_row; last_col = a_col;
                if (exp_cmd.size() == 0) begin
                    fail_now("unexpected_cmd");
                end else begin
                    e = exp_cmd.pop_front();
                    check("cmd_code", 64'(c), 64'(e.cmd));
                    check("cmd_bank_row_col", 64'({a_bank, a_row, a_col}),
                          64'({e.addr[23:22], e.addr[21:9], e.addr[8:0]}));
                    if (e.cmd == 2'd2) check("cmd_wdata", 64'(d), 64'(e.data));
                end
                repeat (env_issue_lat) begin @(posedge clk); #1; end
                sd_status = 1'b1;
                repeat (env_busy_len) @(posedge clk);
                #1;
                check("addr_data_stable", 64'({a_bank, a_row, a_col, d_out}), 64'({a, d}));
                if (c == 2'd2) env_mem[a] = d;
                else           sd_rdata = env_mem.exists(a) ? env_mem[a] : bg(a);
                sd_status = 1'b0;
            end
        end
    end

    // Monitor: every ack/valid pops the scoreboard.
    always @(negedge clk) begin
        if (wr_ack) begin
            wr_exp_t e;
            if (exp_order.size() == 0) fail_now("order_unexpected_wr");
            else check("grant_order", 64'({wr_ack, rd_valid}), exp_order.pop_front() ? 64'd2 : 64'd1);
            if (exp_wr.size() == 0) begin
                fail_now("wr_ack_unexpected");
            end else begin
                e = exp_wr.pop_front();
                check("wr_drop", 64'(wr_drop), 64'(e.drop));
                check("wr_ptr", 64'(wr_ptr), 64'(e.ptr));
                check("mem_full", 64'(mem_full), 64'(e.full));
            end
        end else if (wr_drop) begin
            fail_now("drop_without_ack");
        end
        if (rd_valid) begin
            if (exp_order.size() == 0) fail_now("order_unexpected_rd");
            else check("grant_order", 64'({wr_ack, rd_valid}), exp_order.pop_front() ? 64'd2 : 64'd1);
            if (exp_rd.size() == 0) fail_now("rd_valid_unexpected");
            else check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad_cmd;
        int n;

        // 1: reset, then power-up STATUS pulse
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 64'({cmd_out, wr_ack, wr_drop, rd_valid, mem_full, ready, fault, wr_ptr}), 64'd0);
        check("rst_data", 64'({a_bank, a_row, a_col, d_out, rd_data}), 64'd0);
        rst_n = 1'b1;
        sd_status = 1'b1;
        bad_cmd = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (cmd_out != 2'd0) bad_cmd = 1'b1;
        end
        check("ready_during_init", 64'(ready), 64'd0);
        sd_status = 1'b0;
        @(posedge clk); #1;
        check("ready_after_init", 64'(ready), 64'd1);
        check("init_cmd_idle", 64'(bad_cmd), 64'd0);
        env_mode = 0;

        // 2: directed write
        env_issue_lat = 0; env_busy_len = 12;
        do_phase(1'b1, 16'hBEEF, 1'b0, 24'h0);
        check("t2_ptr", 64'(wr_ptr), 64'd1);

        // 3: directed read with decode
        env_mem[24'hC00205] = 16'h1234;
        ref_mem[24'hC00205] = 16'h1234;
        do_phase(1'b0, 16'h0, 1'b1, 24'hC00205);
        check("t3_decode", 64'({last_bank, last_row, last_col}), 64'({2'd3, 13'd1, 9'd5}));
        check("t3_rd_data", 64'(rd_data), 64'h1234);

        // 4: contention, then randomized mix
        for (int p = 0; p < 4; p++) begin
            env_busy_len = 3 + p;
            do_phase(1'b1, 16'(16'hA000 + p), 1'b1, 24'(p));
        end
        for (int p = 0; p < 40; p++) begin
            int          kind = $urandom_range(0, 2);
            logic [23:0] ra   = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 63)) : 24'($urandom);
            env_issue_lat = $urandom_range(0, 3);
            env_busy_len  = $urandom_range(1, 20);
            do_phase(kind != 1, 16'($urandom), kind != 0, ra);
        end

        // 5: fill to ADDR_MAX, then two more writes
        n = 0;
        env_issue_lat = 0; env_busy_len = 2;
        while (!m_full && n < 70) begin
            do_phase(1'b1, 16'($urandom), 1'b0, 24'h0);
            n++;
        end
        do_phase(1'b1, 16'h1111, 1'b0, 24'h0);
        do_phase(1'b1, 16'h2222, 1'b0, 24'h0);
        check("fill_ptr", 64'(wr_ptr), 64'(m_ptr));
        check("fill_full", 64'(mem_full), 64'(m_full));
        do_phase(1'b0, 16'h0, 1'b1, AMAX);

        // 6: issue timeout, sticky fault, retry, reset mid-BUSY
        env_mode = 1;
        rd_addr = 24'h5;
        rd_req  = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (fault) break;
            if (cmd_out == 2'd1) n++;
        end
        check("fault_set", 64'(fault), 64'd1);
        check("issue_hold_cycles", 64'(n), 64'd16);
        check("fault_cmd_idle", 64'(cmd_out), 64'd0);
        @(posedge clk); #1;
        check("retry_cmd", 64'(cmd_out), 64'd1);
        check("fault_sticky", 64'(fault), 64'd1);
        sd_status = 1'b1;
        @(posedge clk); #1;
        check("busy_cmd_idle", 64'(cmd_out), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ctl", 64'({cmd_out, wr_ack, wr_drop, rd_valid, mem_full, ready, fault, wr_ptr}), 64'd0);
        check("midrst_data", 64'({a_bank, a_row, a_col, d_out, rd_data}), 64'd0);
        rd_req = 1'b0;
        sd_status = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_not_ready", 64'(ready), 64'd0);
        check("sb_drain", 64'(exp_cmd.size() + exp_wr.size() + exp_rd.size() + exp_order.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
